pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
- 32-bit, five-stage pipelined barrel shifter for the execute path.
- Each stage applies one bit of the shift amount: the 16-bit stage first, then 8, 4, 2 and 1.
- Each stage has its own pipeline register; stages are joined by valid/ready flow control.
- Consumes operands from the decode/issue side and feeds the writeback mux at one result per cycle.

Parameters:
- WIDTH, 32, datapath width; fixed at 32 because the stage set 16/8/4/2/1 is hard-wired.
- SHAMT_W, 5, shift-amount width.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all stage valid bits.
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  shifter accepts the operation this cycle.
- data_input  input  32  operand.
- ctrl_shiftamt  input  5  shift amount, 0..31.
- ctrl_shiftop  input  2  operation: 00 SLL, 01 SRA, 10 SRL, 11 ROL (see Optional Feature).
- out_valid  output  1  data_output holds a result.
- out_ready  input  1  downstream takes the result this cycle.
- data_output  output  32  shifted result, registered.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Reset: synchronous; takes priority over every handshake in the same cycle.
  - All five stage valid bits go to 0.
  - out_valid=0, busy=0.
  - in_ready=1 in the cycle after reset deasserts.
  - data_output is cleared to 0x0000_0000.
  - Any in-flight operations are discarded; none of them appear at the output.
- Stage s, for s=1..5 with amount bit b=5-s:
  - Registers {valid, data, remaining shamt, op}.
  - Stage 1 computes from the input ports; stages 2..5 compute from the previous stage register.
  - If shamt[b]=1, the stage shifts by 2^b, else it passes data through unchanged.
- Fill rules per op:
  - SLL: zeros into the LSBs.
  - SRL: zeros into the MSBs.
  - SRA: copies of data[31] into the MSBs, taken from the current stage's data.
- Advance rule:
  - Stage s loads when it is empty or its contents advance this cycle.
  - Stage 5 advances when out_valid & out_ready.
  - Stage s<5 advances when stage s+1 loads.
  - in_ready = stage-1 load condition.
  - Input is accepted when in_valid & in_ready.
- Latency and throughput:
  - An operation accepted at edge N is in stage 5 after edge N+4.
  - out_valid=1 and data_output valid from edge N+4 until the handshake.
  - Throughput: one op per cycle while out_ready=1.
- Stall:
  - With out_ready=0, data_output and out_valid hold stable.
  - Bubbles collapse: an empty stage loads even when its downstream stage is stalled.
  - A full stalled pipe holds exactly 5 ops and drives in_ready=0.
- in_ready is combinational from out_ready through the chain; no combinational path from in_valid to in_ready.
- shamt=0: result equals data_input for every op.
- Ordering is strictly preserved: no reordering and no drops.
- Simultaneous accept and emit in the same cycle is legal and keeps full throughput.

Optional Feature:
- Macro: SHIFTER_ROTATE_EN.
- Defined: op 11 is rotate-left; the bits shifted out of the MSBs re-enter the LSBs at every stage.
- Undefined: op 11 is decoded as SLL, and no rotate logic is synthesised.

Test Plan:
1. SLL 0x0000_0001, shamt 17, out_ready=1, accepted at edge N -> out_valid=1 after edge N+4, data_output=0x0002_0000.
2. SRA 0x8000_0000 shamt 31 -> 0xFFFF_FFFF; then SRL same operands -> 0x0000_0001; then SRA 0x7FFF_FFF0 shamt 4 -> 0x07FF_FFFF.
3. Back-to-back burst, all shamt=1, out_ready held 1, in_valid high five cycles:
   - SLL 0x1 -> 0x2
   - SLL 0x2 -> 0x4
   - SRL 0x8 -> 0x4
   - SRA 0xFFFF_FFFE -> 0xFFFF_FFFF
   - SLL 0x0 -> 0x0
   - Results must appear in that order on five consecutive cycles.
4. out_ready=0 while 6 ops are offered -> 5 accepted, in_ready=0, data_output stable at the first result, busy=1. Raise out_ready -> 6th op accepted that cycle, and all 6 results drain in order with no gaps.
5. Reset asserted for one cycle with 3 ops in flight -> after that edge out_valid=0, busy=0, in_ready=1. None of the 3 results ever appears. A new op afterwards returns correctly with latency N+4.
6. Op 11, 0x8000_0001, shamt 4 -> 0x0000_0018 with SHIFTER_ROTATE_EN defined; 0x0000_0010 without it.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - 32-bit five-stage pipelined barrel shifter (16/8/4/2/1)
// Optional rotate-left for op 11 when SHIFTER_ROTATE_EN is defined.
module pipelined_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_input,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  input  logic [1:0]         ctrl_shiftop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_output,
  output logic               busy
);

  logic [4:0]         vld;
  logic [4:0]         load;
  logic [WIDTH-1:0]   dat [5];
  logic [SHAMT_W-1:0] amt [4];
  logic [1:0]         opr [4];

  // A stage loads when empty or when its occupant moves on; this ripples from the output back.
  assign load[4] = ~vld[4] | (vld[4] & out_ready);
  assign load[3] = ~vld[3] | load[4];
  assign load[2] = ~vld[2] | load[3];
  assign load[1] = ~vld[1] | load[2];
  assign load[0] = ~vld[0] | load[1];

  assign in_ready    = load[0];
  assign out_valid   = vld[4];
  assign data_output = dat[4];
  assign busy        = |vld;

  for (genvar g = 0; g < 5; g++) begin : g_stage
    localparam int K = 1 << (4 - g);

    logic               src_v;
    logic [WIDTH-1:0]   src_d;
    logic [SHAMT_W-1:0] src_a;
    logic [1:0]         src_o;
    logic [WIDTH-1:0]   shifted;
    logic               v_q;
    logic [WIDTH-1:0]   d_q;

    if (g == 0) begin : g_src_port
      assign src_v = in_valid;
      assign src_d = data_input;
      assign src_a = ctrl_shiftamt;
      assign src_o = ctrl_shiftop;
    end else begin : g_src_reg
      assign src_v = vld[g-1];
      assign src_d = dat[g-1];
      assign src_a = amt[g-1];
      assign src_o = opr[g-1];
    end

    always_comb begin
      shifted = src_d;
      if (src_a[4-g]) begin
        case (src_o)
          2'b01:   shifted = $signed(src_d) >>> K;
          2'b10:   shifted = src_d >> K;
`ifdef SHIFTER_ROTATE_EN
          2'b11:   shifted = (src_d << K) | (src_d >> (WIDTH - K));
`endif
          default: shifted = src_d << K;
        endcase
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (load[g]) begin
        v_q <= src_v;
        d_q <= shifted;
      end
    end

    assign vld[g] = v_q;
    assign dat[g] = d_q;

    // The last stage has no downstream shift to steer, so it carries only valid and data.
    if (g < 4) begin : g_ctrl
      logic [SHAMT_W-1:0] a_q;
      logic [1:0]         o_q;
      always_ff @(posedge clock) begin
        if (load[g]) begin
          a_q <= src_a;
          o_q <= src_o;
        end
      end
      assign amt[g] = a_q;
      assign opr[g] = o_q;
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - directed self-checking bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] data_input = '0;
  logic [4:0]  ctrl_shiftamt = '0;
  logic [1:0]  ctrl_shiftop = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] data_output;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_barrel_shifter dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_input(data_input), .ctrl_shiftamt(ctrl_shiftamt), .ctrl_shiftop(ctrl_shiftop),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_output(data_output), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh);
    in_valid      = 1'b1;
    ctrl_shiftop  = op;
    data_input    = d;
    ctrl_shiftamt = sh;
  endtask

  task automatic send_and_check(input string tag, input logic [1:0] op, input logic [31:0] d,
                                input logic [4:0] sh, input logic [31:0] exp);
    out_ready = 1'b1;
    drive(op, d, sh);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, data_output, exp);
    step();
  endtask

  logic [1:0]  b_op  [5] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
  logic [31:0] b_dat [5] = '{32'h1, 32'h2, 32'h8, 32'hFFFF_FFFE, 32'h0};
  logic [31:0] b_exp [5] = '{32'h2, 32'h4, 32'h4, 32'hFFFF_FFFF, 32'h0};
  logic [31:0] rot_exp;

  initial begin
    repeat (3) step();
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_data", data_output, 32'h0);

    send_and_check("sll17", 2'b00, 32'h0000_0001, 5'd17, 32'h0002_0000);
    send_and_check("sra31", 2'b01, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    send_and_check("srl31", 2'b10, 32'h8000_0000, 5'd31, 32'h0000_0001);
    send_and_check("sra4",  2'b01, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF);
    send_and_check("sll0",  2'b00, 32'hA5A5_5A5A, 5'd0,  32'hA5A5_5A5A);
    send_and_check("sra0",  2'b01, 32'h8000_1234, 5'd0,  32'h8000_1234);
    send_and_check("srl0",  2'b10, 32'hF00D_BEEF, 5'd0,  32'hF00D_BEEF);

    // Back-to-back burst with shamt=1
    for (int t = 0; t < 9; t++) begin
      if (t < 5) drive(b_op[t], b_dat[t], 5'd1);
      else in_valid = 1'b0;
      step();
      if (t >= 4) begin
        check($sformatf("burst%0d_valid", t - 4), {31'd0, out_valid}, 32'd1);
        check($sformatf("burst%0d_data", t - 4), data_output, b_exp[t - 4]);
      end
    end
    step();
    check("burst_drained", {31'd0, out_valid}, 32'd0);

    // Stall: six ops offered with out_ready low, SLL 1 by k+1
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(2'b00, 32'h1, 5'(k + 1));
      step();
    end
    drive(2'b00, 32'h1, 5'd6);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_busy", {31'd0, busy}, 32'd1);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_data", data_output, 32'h2);
    repeat (2) step();
    check("stall_hold_data", data_output, 32'h2);
    check("stall_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      check($sformatf("drain%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("drain%0d_data", k), data_output, 32'h1 << (k + 1));
      step();
    end
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      drive(2'b10, 32'hDEAD_0000 + 32'(k), 5'd0);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_data", data_output, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("flush_quiet%0d", k), {31'd0, out_valid}, 32'd0);
    end
    send_and_check("post_rst", 2'b00, 32'h0000_0003, 5'd8, 32'h0000_0300);

`ifdef SHIFTER_ROTATE_EN
    rot_exp = 32'h0000_0018;
`else
    rot_exp = 32'h0000_0010;
`endif
    send_and_check("op11", 2'b11, 32'h8000_0001, 5'd4, rot_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
